// File: rtl/shift_pipe_elastic.sv
// Elastic valid/data shift pipeline with ready/valid handshake on both sides.
// Backpressure is either bubble-collapsing per stage or a global stall.
module shift_pipe_elastic #(
  parameter int unsigned width_p    = 32,
  parameter int unsigned stages_p   = 4,
  parameter int unsigned collapse_p = 1
) (
  input  logic                             clk,
  input  logic                             reset_ni,
  input  logic                             flush_i,
  input  logic                             valid_i,
  input  logic [width_p-1:0]               data_i,
  output logic                             ready_o,
  output logic                             valid_o,
  output logic [width_p-1:0]               data_o,
  input  logic                             ready_i,
  output logic [$clog2(stages_p+1)-1:0]    count_o,
  output logic                             empty_o,
  output logic                             full_o
);

  localparam int unsigned CountW = $clog2(stages_p + 1);

  logic [stages_p-1:0] v_q, v_d;
  logic [width_p-1:0]  d_q [stages_p];
  logic [width_p-1:0]  d_d [stages_p];
  logic [stages_p-1:0] en;
  logic [stages_p:0]   v_src;
  logic [width_p-1:0]  d_src [stages_p+1];
  logic [CountW-1:0]   count_q, count_d;
  logic                in_xfer, out_xfer;

  // Stage enables: collapse mode lets a stage advance when it is empty or
  // its successor advances, so bubbles are squeezed out under a stall.
  always_comb begin
    logic chain;
    en    = '0;
    chain = 1'b0;
    if (collapse_p != 0) begin
      chain = !v_q[stages_p-1] | ready_i;
      en[stages_p-1] = chain;
      for (int unsigned k = 1; k < stages_p; k++) begin
        chain = !v_q[stages_p-1-k] | chain;
        en[stages_p-1-k] = chain;
      end
    end else begin
      en = {stages_p{!(v_q[stages_p-1] & !ready_i)}};
    end
  end

  assign ready_o  = en[0] & !flush_i;
  assign in_xfer  = valid_i & ready_o;
  assign out_xfer = v_q[stages_p-1] & ready_i;

  always_comb begin
    v_src    = {v_q, valid_i};
    d_src[0] = data_i;
    for (int unsigned i = 0; i < stages_p; i++) begin
      d_src[i+1] = d_q[i];
    end
    v_d = v_q;
    d_d = d_q;
    if (flush_i) begin
      v_d = '0;
    end else begin
      for (int unsigned i = 0; i < stages_p; i++) begin
        if (en[i]) begin
          v_d[i] = v_src[i];
          // Data only moves with a valid entry; bubbles leave it untouched.
          if (v_src[i]) begin
            d_d[i] = d_src[i];
          end
        end
      end
    end
    if (flush_i) begin
      count_d = '0;
    end else begin
      count_d = count_q + CountW'(in_xfer) - CountW'(out_xfer);
    end
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      v_q     <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < stages_p; i++) begin
        d_q[i] <= '0;
      end
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
      for (int unsigned i = 0; i < stages_p; i++) begin
        d_q[i] <= d_d[i];
      end
    end
  end

  assign valid_o = v_q[stages_p-1];
  assign data_o  = d_q[stages_p-1];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CountW'(stages_p));

endmodule
